// File: rtl/aes_inv_mixcolumns.sv
// Serial AES InvMixColumns engine for the decrypt datapath.
// Accumulates MACS_PER_CYCLE GF(2^8) byte-products per clock over the inverse
// matrix and publishes the finished 4x4 result when the run completes.
module aes_inv_mixcolumns #(
    parameter int unsigned MACS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic [31:0] state0,
    input  logic [31:0] state1,
    input  logic [31:0] state2,
    input  logic [31:0] state3,
    output logic [31:0] state_out0,
    output logic [31:0] state_out1,
    output logic [31:0] state_out2,
    output logic [31:0] state_out3,
    output logic        done,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] LAST_CNT = 6'(64 - MACS_PER_CYCLE);
    localparam logic [1:0] K_SPAN   = 2'(MACS_PER_CYCLE - 1);
    localparam logic [5:0] CNT_STEP = 6'(MACS_PER_CYCLE);

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply for the four inverse-matrix coefficients.
    function automatic logic [7:0] gmul(input logic [7:0] coef, input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            8'h09:   gmul = x8 ^ b;
            8'h0b:   gmul = x8 ^ x2 ^ b;
            8'h0d:   gmul = x8 ^ x4 ^ b;
            8'h0e:   gmul = x8 ^ x4 ^ x2;
            default: gmul = '0;
        endcase
    endfunction

    // Inverse matrix is circulant: each row is row 0 rotated right by r.
    function automatic logic [7:0] coef_at(input logic [1:0] r, input logic [1:0] k);
        logic [1:0] d;
        d = k - r;
        case (d)
            2'd0:    coef_at = 8'h0e;
            2'd1:    coef_at = 8'h0b;
            2'd2:    coef_at = 8'h0d;
            default: coef_at = 8'h09;
        endcase
    endfunction

    logic [1:0]        fsm;
    logic              start_q;
    logic              start;
    logic [3:0][31:0]  in_reg;
    logic [5:0]        cnt;
    logic [7:0]        acc;
    logic [7:0]        sum;
    logic [1:0]        k_cur;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              last_k;
    logic              last_step;
    logic [15:0][7:0]  res;
    logic [15:0][7:0]  res_final;
    logic [3:0][31:0]  out_reg;

    assign start     = start_in & ~start_q;
    assign col       = cnt[5:4];
    assign row       = cnt[3:2];
    assign last_k    = (cnt[1:0] + K_SPAN) == 2'd3;
    assign last_step = (cnt == LAST_CNT);

    assign done       = (fsm == DONE);
    assign busy       = (fsm == RUN);
    assign state_out0 = out_reg[0];
    assign state_out1 = out_reg[1];
    assign state_out2 = out_reg[2];
    assign state_out3 = out_reg[3];

    // XOR this cycle's products for k..k+M-1 into the running accumulator.
    always_comb begin
        sum   = acc;
        k_cur = '0;
        for (int unsigned j = 0; j < MACS_PER_CYCLE; j++) begin
            k_cur = cnt[1:0] + 2'(j);
            sum   = sum ^ gmul(coef_at(row, k_cur), in_reg[col][{k_cur, 3'b000} +: 8]);
        end
    end

    // Result array with the byte finishing this cycle merged in, so the last
    // byte reaches the outputs on the same edge that enters DONE.
    always_comb begin
        res_final           = res;
        res_final[cnt[5:2]] = sum;
    end

    // Start-edge detector register.
    always_ff @(posedge clk) begin
        if (reset) start_q <= 1'b0;
        else       start_q <= start_in;
    end

    // Control FSM and iterative multiply-accumulate datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm     <= IDLE;
            in_reg  <= '0;
            cnt     <= '0;
            acc     <= '0;
            res     <= '0;
            out_reg <= '0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (start) begin
                        fsm    <= RUN;
                        in_reg <= {state3, state2, state1, state0};
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        fsm <= IDLE;
                    end
                end
                RUN: begin
                    if (last_k) begin
                        res <= res_final;
                        acc <= '0;
                    end else begin
                        acc <= sum;
                    end
                    if (last_step) begin
                        fsm     <= DONE;
                        cnt     <= '0;
                        out_reg <= res_final;
                    end else begin
                        cnt <= cnt + CNT_STEP;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mixcolumns.sv
// Bench for aes_inv_mixcolumns: directed vectors, round trip through a
// behavioural MixColumns, random columns, start/reset corner cases, and the
// M=2 / M=4 variants running alongside the M=1 instance.
module tb_aes_inv_mixcolumns;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             start_in;
    logic [3:0][31:0] st;
    logic [3:0][31:0] o1, o2, o4;
    logic             done1, busy1, done2, busy2, done4, busy4;

    int checks = 0;
    int errors = 0;

    aes_inv_mixcolumns #(.MACS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .start_in(start_in),
        .state0(st[0]), .state1(st[1]), .state2(st[2]), .state3(st[3]),
        .state_out0(o1[0]), .state_out1(o1[1]), .state_out2(o1[2]), .state_out3(o1[3]),
        .done(done1), .busy(busy1)
    );

    aes_inv_mixcolumns #(.MACS_PER_CYCLE(2)) dut2 (
        .clk(clk), .reset(reset), .start_in(start_in),
        .state0(st[0]), .state1(st[1]), .state2(st[2]), .state3(st[3]),
        .state_out0(o2[0]), .state_out1(o2[1]), .state_out2(o2[2]), .state_out3(o2[3]),
        .done(done2), .busy(busy2)
    );

    aes_inv_mixcolumns #(.MACS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start_in(start_in),
        .state0(st[0]), .state1(st[1]), .state2(st[2]), .state3(st[3]),
        .state_out0(o4[0]), .state_out1(o4[1]), .state_out2(o4[2]), .state_out3(o4[3]),
        .done(done4), .busy(busy4)
    );

    // Generic GF(2^8) multiply, shift-and-add with reduction by 0x11b.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Column times a circulant matrix whose first row is {c0,c1,c2,c3}.
    function automatic logic [31:0] col_mul(input logic [31:0] w,
                                            input logic [7:0] c0, input logic [7:0] c1,
                                            input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0]  cf [4];
        logic [7:0]  a;
        logic [31:0] r_w;
        cf[0] = c0; cf[1] = c1; cf[2] = c2; cf[3] = c3;
        r_w = '0;
        for (int r = 0; r < 4; r++) begin
            a = '0;
            for (int k = 0; k < 4; k++)
                a = a ^ gm(cf[(k - r + 4) % 4], w[8*k +: 8]);
            r_w[8*r +: 8] = a;
        end
        return r_w;
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] w);
        return col_mul(w, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        return col_mul(w, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0][31:0] obs,
                              input logic [3:0][31:0] exp);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_w%0d", tag, i), obs[i], exp[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start_in with data w, scramble inputs after the accepting edge,
    // and record the first done cycle of each instance plus M=1 done count.
    task automatic run_op(input logic [3:0][31:0] w, output int l1, output int l2,
                          output int l4, output int nd);
        l1 = 0; l2 = 0; l4 = 0; nd = 0;
        st = w;
        start_in = 1'b1;
        for (int n = 1; n <= 75; n++) begin
            tick();
            if (n == 1) st = {$urandom, $urandom, $urandom, $urandom};
            if (done1) begin
                nd++;
                if (l1 == 0) l1 = n;
            end
            if (done2 && l2 == 0) l2 = n;
            if (done4 && l4 == 0) l4 = n;
        end
        start_in = 1'b0;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][31:0] v1, e1, v2, e2, orig, w, e;
        int l1, l2, l4, nd, mism, n;

        v1 = {4{32'hbca14d8e}};
        e1 = {4{32'h455313db}};
        v2 = {32'hc6c6c6c6, 32'h01010101, 32'hd6d7d5d5, 32'h9d58dc9f};
        e2 = {32'hc6c6c6c6, 32'h01010101, 32'hd5d4d4d4, 32'h5c220af2};

        reset = 1'b1; start_in = 1'b0; st = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_done", 32'(done1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check_outs("rst_out1", o1, '0);
        check_outs("rst_out4", o4, '0);

        // Known vector 1 on all three widths.
        run_op(v1, l1, l2, l4, nd);
        check("v1_lat1", 32'(l1), 32'd65);
        check("v1_lat2", 32'(l2), 32'd33);
        check("v1_lat4", 32'(l4), 32'd17);
        check("v1_ndone", 32'(nd), 32'd1);
        check("v1_busy_after", 32'(busy1), 32'd0);
        check_outs("v1_o1", o1, e1);
        check_outs("v1_o2", o2, e1);
        check_outs("v1_o4", o4, e1);
        for (int i = 0; i < 4; i++) e[i] = inv_col(v1[i]);
        check_outs("v1_model", o1, e);

        // Known vector 2.
        run_op(v2, l1, l2, l4, nd);
        check("v2_lat1", 32'(l1), 32'd65);
        check_outs("v2_o1", o1, e2);
        check_outs("v2_o4", o4, e2);

        // Round trip through the reference MixColumns.
        orig = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
        for (int i = 0; i < 4; i++) w[i] = mix_col(orig[i]);
        run_op(w, l1, l2, l4, nd);
        check("rt_lat1", 32'(l1), 32'd65);
        check("rt_lat2", 32'(l2), 32'd33);
        check("rt_lat4", 32'(l4), 32'd17);
        check_outs("rt_o1", o1, orig);
        check_outs("rt_o2", o2, orig);
        check_outs("rt_o4", o4, orig);

        // Random columns against the model.
        for (int t = 0; t < 3; t++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) e[i] = inv_col(w[i]);
            run_op(w, l1, l2, l4, nd);
            check($sformatf("rnd%0d_lat1", t), 32'(l1), 32'd65);
            check_outs($sformatf("rnd%0d_o1", t), o1, e);
            check_outs($sformatf("rnd%0d_o2", t), o2, e);
            check_outs($sformatf("rnd%0d_o4", t), o4, e);
        end

        // start_in pulses during RUN are ignored.
        st = v1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        st = {$urandom, $urandom, $urandom, $urandom};
        nd = 0; l1 = 0;
        for (n = 2; n <= 90; n++) begin
            start_in = (n >= 10 && n <= 13 && (n % 2) == 0);
            tick();
            if (n == 20) check("run_pulse_busy", 32'(busy1), 32'd1);
            if (done1) begin
                nd++;
                if (l1 == 0) l1 = n;
            end
        end
        start_in = 1'b0;
        check("run_pulse_ndone", 32'(nd), 32'd1);
        check("run_pulse_lat", 32'(l1), 32'd65);
        check_outs("run_pulse_o1", o1, e1);

        // Held-high start_in for 200 cycles gives exactly one operation.
        st = v2; start_in = 1'b1; nd = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done1) nd++;
        end
        start_in = 1'b0;
        tick();
        check("hold_ndone", 32'(nd), 32'd1);
        check_outs("hold_o1", o1, e2);

        // Reset in the middle of a run aborts it.
        st = v2; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (n = 2; n <= 30; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("midrst_o1", o1, '0);
        check("midrst_done", 32'(done1), 32'd0);
        check("midrst_busy", 32'(busy1), 32'd0);
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done1) nd++;
        end
        check("midrst_nodone", 32'(nd), 32'd0);
        run_op(v1, l1, l2, l4, nd);
        check("postrst_lat1", 32'(l1), 32'd65);
        check_outs("postrst_o1", o1, e1);

        // Back-to-back: new start edge during the DONE cycle.
        st = v2; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n = 1;
        while (!done1 && n < 100) begin
            tick();
            n++;
        end
        check("b2b_first_done", 32'(done1), 32'd1);
        check_outs("b2b_first_o1", o1, e2);
        st = v1; start_in = 1'b1;
        l1 = 0; mism = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 1) begin
                start_in = 1'b0;
                st = {$urandom, $urandom, $urandom, $urandom};
            end
            if (done1 && l1 == 0) l1 = i;
            if (l1 == 0 && o1 !== e2) mism++;
        end
        check("b2b_gap", 32'(l1), 32'd65);
        check("b2b_held", 32'(mism), 32'd0);
        check_outs("b2b_second_o1", o1, e1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
